// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - RV32I multi-cycle FETCH/DECODE/EXECUTE/MEM/WB control sequencer
// Define CSR_EN to build the SYSTEM (CSR) state; without it opcode 1110011 faults as illegal.
module multicycle_control_unit #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] imm_type,
  output logic       csr_we,
  output logic       illegal,
  output logic       bus_error,
  output logic [3:0] state
);

  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
`ifdef CSR_EN
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
`endif

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  typedef enum logic [3:0] {
    ST_BOOT     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_EXEC_R   = 4'd3,
    ST_EXEC_I   = 4'd4,
    ST_MEM_ADDR = 4'd5,
    ST_MEM_RD   = 4'd6,
    ST_MEM_WR   = 4'd7,
    ST_BRANCH   = 4'd8,
    ST_JAL      = 4'd9,
    ST_JALR     = 4'd10,
    ST_UPPER    = 4'd11,
`ifdef CSR_EN
    ST_SYSTEM   = 4'd12,
`endif
    ST_FAULT    = 4'd13
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          illegal_q, illegal_d;
  logic          bus_error_q, bus_error_d;
  logic          mem_wait;
  logic [CW-1:0] cnt_inc;

  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    illegal_d   = illegal_q;
    bus_error_d = bus_error_q;
    mem_wait    = 1'b0;
    case (state_q)
      ST_BOOT:   state_d = ST_FETCH;
      ST_FETCH: begin
        if (mem_ready) state_d = ST_DECODE;
        else           mem_wait = 1'b1;
      end
      ST_DECODE: begin
        case (opcode)
          OP_R:               state_d = ST_EXEC_R;
          OP_I:               state_d = ST_EXEC_I;
          OP_LOAD, OP_STORE:  state_d = ST_MEM_ADDR;
          OP_BRANCH:          state_d = ST_BRANCH;
          OP_JAL:             state_d = ST_JAL;
          OP_JALR:            state_d = ST_JALR;
          OP_LUI, OP_AUIPC:   state_d = ST_UPPER;
`ifdef CSR_EN
          OP_SYSTEM:          state_d = ST_SYSTEM;
`endif
          default: begin
            state_d   = ST_FAULT;
            illegal_d = 1'b1;
          end
        endcase
      end
      ST_EXEC_R, ST_EXEC_I, ST_BRANCH, ST_JAL, ST_JALR, ST_UPPER: state_d = ST_FETCH;
`ifdef CSR_EN
      ST_SYSTEM: state_d = ST_FETCH;
`endif
      // opcode[5] separates store (0100011) from load (0000011)
      ST_MEM_ADDR: state_d = opcode[5] ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD, ST_MEM_WR: begin
        if (mem_ready) state_d = ST_FETCH;
        else           mem_wait = 1'b1;
      end
      ST_FAULT: state_d = ST_FAULT;
      default: begin
        state_d   = ST_FAULT;
        illegal_d = 1'b1;
      end
    endcase

    // Counter only survives while stalled in the same memory state; any entry starts it at zero.
    if (mem_wait) begin
      cnt_d = cnt_inc;
      if ((MEM_TIMEOUT != 0) && (cnt_inc == CW'(MEM_TIMEOUT))) begin
        state_d     = ST_FAULT;
        bus_error_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_BOOT;
      cnt_q       <= '0;
      illegal_q   <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      illegal_q   <= illegal_d;
      bus_error_q <= bus_error_d;
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 2'd0;
    reg_write = 1'b0;
    wb_sel    = 2'd0;
    alu_src_a = 2'd0;
    alu_src_b = 2'd0;
    imm_type  = IMM_I;
    csr_we    = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_req   = 1'b1;
        alu_src_a = 2'd1;
        alu_src_b = 2'd2;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      ST_EXEC_R: reg_write = 1'b1;
      ST_EXEC_I: begin
        alu_src_b = 2'd1;
        reg_write = 1'b1;
      end
      ST_MEM_ADDR: begin
        alu_src_b = 2'd1;
        imm_type  = opcode[5] ? IMM_S : IMM_I;
      end
      ST_MEM_RD: begin
        mem_req   = 1'b1;
        addr_sel  = 1'b1;
        reg_write = mem_ready;
        wb_sel    = {1'b0, mem_ready};
      end
      ST_MEM_WR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        addr_sel = 1'b1;
      end
      ST_BRANCH: begin
        imm_type = IMM_B;
        pc_src   = 2'd1;
        pc_write = branch_taken;
      end
      ST_JAL: begin
        imm_type  = IMM_J;
        pc_src    = 2'd1;
        pc_write  = 1'b1;
        reg_write = 1'b1;
        wb_sel    = 2'd2;
      end
      ST_JALR: begin
        alu_src_b = 2'd1;
        pc_src    = 2'd2;
        pc_write  = 1'b1;
        reg_write = 1'b1;
        wb_sel    = 2'd2;
      end
      // LUI adds the immediate to zero, AUIPC to the instruction's own PC
      ST_UPPER: begin
        imm_type  = IMM_U;
        alu_src_a = opcode[5] ? 2'd2 : 2'd3;
        alu_src_b = 2'd1;
        reg_write = 1'b1;
      end
`ifdef CSR_EN
      ST_SYSTEM: begin
        reg_write = 1'b1;
        wb_sel    = 2'd3;
        csr_we    = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign illegal   = illegal_q;
  assign bus_error = bus_error_q;
  assign state     = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - randomized, model-checked bench for multicycle_control_unit
`timescale 1ns/1ps
module tb_multicycle_control_unit;
  localparam int TO = 4;
  localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_JAL = 5, K_JALR = 6;
  localparam int K_LUI = 7, K_AUIPC = 8, K_SYS = 9, K_ILL = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic       branch_taken = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, addr_sel, ir_write, pc_write, reg_write, csr_we, illegal, bus_error;
  logic [1:0] pc_src, wb_sel, alu_src_a, alu_src_b;
  logic [2:0] imm_type;
  logic [3:0] state;

  always #5 clk = ~clk;

  multicycle_control_unit #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .reg_write(reg_write), .wb_sel(wb_sel), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .imm_type(imm_type), .csr_we(csr_we), .illegal(illegal),
    .bus_error(bus_error), .state(state)
  );

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [2:0] imm;
    logic       csr_we;
    logic       illegal;
    logic       bus_error;
  } outs_t;

  typedef struct packed {
    logic        rdy;
    logic        tk;
    logic [6:0]  op;
    outs_t       exp;
    logic [63:0] tag;
  } step_t;

  step_t       q[$];
  step_t       cur;
  logic        cur_valid = 1'b0;
  int          checks = 0;
  int          failures = 0;
  logic [63:0] prev_tag = '0;
  logic [3:0]  prev_state = '0;

  function automatic outs_t dut_outs();
    return {mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, reg_write, wb_sel,
            alu_src_a, alu_src_b, imm_type, csr_we, illegal, bus_error};
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] rop();
    return 7'($urandom);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Single compare process: every meaningful cycle is checked against the model's expectation.
  always begin
    @(negedge clk);
    #3;
    if (cur_valid) begin
      checks++;
      if (dut_outs() !== cur.exp) begin
        failures++;
        $display("FAIL step %s at %0t: outputs got %h want %h (op=%b rdy=%b tk=%b)",
                 cur.tag, $time, dut_outs(), cur.exp, cur.op, cur.rdy, cur.tk);
      end
      if (cur.tag == "FAULT   " && prev_tag == "FAULT   ") begin
        checks++;
        if (state !== prev_state) begin
          failures++;
          $display("FAIL fault_hold: state got %0d want %0d", state, prev_state);
        end
      end
      prev_tag   = cur.tag;
      prev_state = state;
    end else begin
      prev_tag = '0;
    end
  end

  task automatic push(input logic rdy, input logic tk, input logic [6:0] op, input outs_t e,
                      input logic [63:0] tag);
    step_t s;
    s.rdy = rdy;
    s.tk  = tk;
    s.op  = op;
    s.exp = e;
    s.tag = tag;
    q.push_back(s);
  endtask

  task automatic gen_fault(input logic ill, input logic bus);
    outs_t e;
    e = '0;
    e.illegal   = ill;
    e.bus_error = bus;
    for (int i = 0; i < 5; i++) push(rbit(), rbit(), rop(), e, "FAULT   ");
  endtask

  task automatic mem_phase(input int d, input outs_t wait_e, input outs_t done_e, input logic [6:0] op,
                           input logic [63:0] tag, output logic ok);
    int waits;
    waits = (d >= TO) ? TO : d;
    for (int i = 0; i < waits; i++) push(1'b0, rbit(), op, wait_e, tag);
    if (d >= TO) begin
      gen_fault(1'b0, 1'b1);
      ok = 1'b0;
    end else begin
      push(1'b1, rbit(), op, done_e, tag);
      ok = 1'b1;
    end
  endtask

  function automatic int classify(input logic [6:0] op);
    int k;
    k = K_ILL;
    case (op)
      7'b0110011: k = K_R;
      7'b0010011: k = K_I;
      7'b0000011: k = K_LD;
      7'b0100011: k = K_ST;
      7'b1100011: k = K_BR;
      7'b1101111: k = K_JAL;
      7'b1100111: k = K_JALR;
      7'b0110111: k = K_LUI;
      7'b0010111: k = K_AUIPC;
`ifdef CSR_EN
      7'b1110011: k = K_SYS;
`endif
      default:    k = K_ILL;
    endcase
    return k;
  endfunction

  // Expected per-cycle outputs of one whole instruction: fetch wait df, memory wait dm.
  task automatic gen_instr(input logic [6:0] op, input int df, input int dm, input logic tk,
                           output logic alive);
    outs_t w, d, e;
    logic  ok;
    int    kind;
    kind = classify(op);
    w = '0;
    w.mem_req = 1'b1;
    w.src_a   = 2'd1;
    w.src_b   = 2'd2;
    d = w;
    d.ir_write = 1'b1;
    d.pc_write = 1'b1;
    mem_phase(df, w, d, rop(), "FETCH   ", ok);
    alive = ok;
    if (!ok) return;
    e = '0;
    push(rbit(), rbit(), op, e, "DECODE  ");
    case (kind)
      K_R: begin
        e.reg_write = 1'b1;
        push(rbit(), rbit(), op, e, "EXEC    ");
      end
      K_I: begin
        e.reg_write = 1'b1;
        e.src_b     = 2'd1;
        push(rbit(), rbit(), op, e, "EXEC    ");
      end
      K_LD, K_ST: begin
        e.src_b = 2'd1;
        e.imm   = (kind == K_ST) ? 3'd1 : 3'd0;
        push(rbit(), rbit(), op, e, "MEMADDR ");
        w = '0;
        w.mem_req  = 1'b1;
        w.addr_sel = 1'b1;
        w.mem_we   = (kind == K_ST);
        d = w;
        if (kind == K_LD) begin
          d.reg_write = 1'b1;
          d.wb_sel    = 2'd1;
        end
        mem_phase(dm, w, d, op, (kind == K_ST) ? "MEMWR   " : "MEMRD   ", ok);
        alive = ok;
      end
      K_BR: begin
        e.imm      = 3'd2;
        e.pc_src   = 2'd1;
        e.pc_write = tk;
        push(rbit(), tk, op, e, "BRANCH  ");
      end
      K_JAL: begin
        e.imm       = 3'd4;
        e.pc_src    = 2'd1;
        e.pc_write  = 1'b1;
        e.reg_write = 1'b1;
        e.wb_sel    = 2'd2;
        push(rbit(), rbit(), op, e, "JUMP    ");
      end
      K_JALR: begin
        e.src_b     = 2'd1;
        e.pc_src    = 2'd2;
        e.pc_write  = 1'b1;
        e.reg_write = 1'b1;
        e.wb_sel    = 2'd2;
        push(rbit(), rbit(), op, e, "JUMP    ");
      end
      K_LUI, K_AUIPC: begin
        e.imm       = 3'd3;
        e.src_a     = (kind == K_LUI) ? 2'd2 : 2'd3;
        e.src_b     = 2'd1;
        e.reg_write = 1'b1;
        push(rbit(), rbit(), op, e, "UPPER   ");
      end
      K_SYS: begin
        e.reg_write = 1'b1;
        e.wb_sel    = 2'd3;
        e.csr_we    = 1'b1;
        push(rbit(), rbit(), op, e, "SYSTEM  ");
      end
      default: begin
        gen_fault(1'b1, 1'b0);
        alive = 1'b0;
      end
    endcase
  endtask

  task automatic apply(input step_t s);
    mem_ready    = s.rdy;
    branch_taken = s.tk;
    opcode       = s.op;
    cur          = s;
    cur_valid    = 1'b1;
  endtask

  task automatic run_queue();
    while (q.size() > 0) begin
      @(negedge clk);
      apply(q.pop_front());
    end
  endtask

  task automatic do_reset();
    step_t b;
    @(negedge clk);
    cur_valid    = 1'b0;
    rst_n        = 1'b0;
    mem_ready    = 1'b1;
    branch_taken = 1'b1;
    opcode       = 7'b0110011;
    #2 chk("reset_outputs", {12'd0, dut_outs()}, 32'd0);
    @(negedge clk);
    #1 chk("reset_hold_outputs", {12'd0, dut_outs()}, 32'd0);
    rst_n = 1'b1;
    b.rdy = rbit();
    b.tk  = rbit();
    b.op  = rop();
    b.exp = '0;
    b.tag = "BOOT    ";
    apply(b);
  endtask

  function automatic logic [6:0] pick_op();
    logic [6:0] legal [10];
    legal = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
              7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1110011};
    if ($urandom_range(0, 24) == 0) return rop();
    return legal[$urandom_range(0, 9)];
  endfunction

  initial begin
    logic alive;
    int   n_rd, n_rw, df, dm;
    outs_t fw;

    // addi with zero-wait memory takes 3 cycles
    do_reset();
    gen_instr(7'b0010011, 0, 0, 1'b0, alive);
    chk("model_addi_len", 32'(q.size()), 32'd3);
    chk("model_first_fetch_req", {31'd0, q[0].exp.mem_req}, 32'd1);
    chk("model_addi_src_b", {30'd0, q[2].exp.src_b}, 32'd1);
    run_queue();

    // load with 3 wait cycles in MEM_RD, then a zero-wait store
    gen_instr(7'b0000011, 0, 3, 1'b0, alive);
    chk("model_load_len", 32'(q.size()), 32'd7);
    n_rd = 0;
    n_rw = 0;
    foreach (q[i]) if (q[i].tag == "MEMRD   ") begin
      n_rd++;
      if (q[i].exp.reg_write) n_rw++;
    end
    chk("model_load_req_cycles", n_rd, 32'd4);
    chk("model_load_wb_cycles", n_rw, 32'd1);
    gen_instr(7'b0100011, 0, 0, 1'b0, alive);
    chk("model_store_len", 32'(q.size()), 32'd11);
    chk("model_store_we", {31'd0, q[10].exp.mem_we}, 32'd1);
    run_queue();

    // branches taken / not taken, JAL, LUI, AUIPC, JALR
    gen_instr(7'b1100011, 0, 0, 1'b1, alive);
    chk("model_br_taken_pcw", {31'd0, q[2].exp.pc_write}, 32'd1);
    gen_instr(7'b1100011, 1, 0, 1'b0, alive);
    gen_instr(7'b1101111, 0, 0, 1'b0, alive);
    gen_instr(7'b0110111, 0, 0, 1'b0, alive);
    gen_instr(7'b0010111, 2, 0, 1'b0, alive);
    gen_instr(7'b1100111, 0, 0, 1'b0, alive);
    run_queue();

    // SYSTEM depends on CSR_EN
    do_reset();
    gen_instr(7'b1110011, 0, 0, 1'b0, alive);
`ifdef CSR_EN
    chk("model_sys_csr_we", {31'd0, q[2].exp.csr_we}, 32'd1);
`else
    chk("model_sys_illegal", {31'd0, q[2].exp.illegal}, 32'd1);
`endif
    run_queue();

    // illegal opcode 0000000, sticky until reset (reset applied mid-cycle)
    do_reset();
    gen_instr(7'b0000000, 0, 0, 1'b0, alive);
    chk("model_illegal_end", {31'd0, q[q.size()-1].exp.illegal}, 32'd1);
    run_queue();
    @(negedge clk);
    cur_valid = 1'b0;
    #1 chk("illegal_before_reset", {31'd0, illegal}, 32'd1);
    rst_n = 1'b0;
    #1 chk("illegal_after_async_reset", {31'd0, illegal}, 32'd0);

    // fetch timeout, then ready on the expiry cycle, then MEM_RD timeout
    do_reset();
    gen_instr(7'b0010011, TO, 0, 1'b0, alive);
    chk("model_fetch_timeout_len", 32'(q.size()), 32'd9);
    run_queue();
    do_reset();
    gen_instr(7'b0010011, TO - 1, 0, 1'b0, alive);
    chk("model_expiry_ready_len", 32'(q.size()), 32'd6);
    run_queue();
    do_reset();
    gen_instr(7'b0000011, 0, TO, 1'b0, alive);
    run_queue();

    // reset pulsed mid-FETCH drops mem_req at once
    do_reset();
    fw = '0;
    fw.mem_req = 1'b1;
    fw.src_a   = 2'd1;
    fw.src_b   = 2'd2;
    push(1'b0, 1'b0, rop(), fw, "FETCH   ");
    push(1'b0, 1'b1, rop(), fw, "FETCH   ");
    run_queue();
    @(negedge clk);
    cur_valid = 1'b0;
    mem_ready = 1'b0;
    #1 chk("pre_reset_mem_req", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    #1 chk("mid_fetch_reset_mem_req", {31'd0, mem_req}, 32'd0);
    chk("mid_fetch_reset_flags", {30'd0, illegal, bus_error}, 32'd0);

    // randomized instruction streams
    for (int blk = 0; blk < 30; blk++) begin
      do_reset();
      for (int n = 0; n < 25; n++) begin
        df = ($urandom_range(0, 19) == 0) ? TO : int'($urandom_range(0, TO - 1));
        dm = ($urandom_range(0, 19) == 0) ? TO : int'($urandom_range(0, TO - 1));
        gen_instr(pick_op(), df, dm, rbit(), alive);
        if (!alive) break;
      end
      run_queue();
    end

    @(negedge clk);
    cur_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
